// File: rtl/cpu_pkg.sv
// Shared CPU definitions: data-processing opcodes, condition codes, NZCV bit
// positions and the execute-stage FSM state type.
package cpu_pkg;

    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

    // TST/TEQ/CMP/CMN occupy opcodes 8..11: flags only, never a register write.
    function automatic logic is_compare(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/alu_cond_check.sv
// Combinational ARM condition evaluation of cond against NZCV; shared with the
// branch unit.
module alu_cond_check
    import cpu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[NZCV_N];
    assign z = nzcv[NZCV_Z];
    assign c = nzcv[NZCV_C];
    assign v = nzcv[NZCV_V];

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flags_stage.sv
// ARM data-processing execute stage with condition check, registered result
// and NZCV commit. Define ALU_MUL_EN to add a 32-cycle shift-add multiplier.
module alu_flags_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        opcode,
    input  logic              s_bit,
    input  logic [3:0]        cond,
    input  logic [3:0]        rd_tag,
    input  logic [DATA_W-1:0] rn,
    input  logic [DATA_W-1:0] op2,
    input  logic              shift_c,
    input  logic              op_mul,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        rd_out,
    output logic              wr_en,
    output logic [3:0]        nzcv,
    output alu_state_e        fsm_state
);

    // Handshake: a transfer occurs on a clk edge where valid && ready; the
    // result register may drain and reload on the same edge.
    alu_state_e state, state_next;
    logic accept, cond_pass, start_mul, mul_done, load, load_wr;
    logic [DATA_W-1:0] load_result, mul_result;
    logic [3:0] load_rd, load_nzcv, mul_rd;
    logic mul_s;

    alu_cond_check u_cond (
        .cond (cond),
        .nzcv (nzcv),
        .pass (cond_pass)
    );

    assign op_ready  = (state == ST_IDLE) && (!res_valid || res_ready);
    assign accept    = op_valid && op_ready;
    assign fsm_state = state;

    logic [DATA_W-1:0] add_a, add_b, logic_res, alu_res;
    logic [DATA_W:0]   sum;
    logic add_cin, is_arith, alu_c, alu_v;
    logic [3:0] alu_nzcv;

    // Subtracts are a + ~b + carry, so one adder yields C as NOT borrow.
    always_comb begin
        add_a     = rn;
        add_b     = op2;
        add_cin   = 1'b0;
        is_arith  = 1'b1;
        logic_res = '0;
        case (opcode)
            OP_SUB, OP_CMP: begin add_b = ~op2; add_cin = 1'b1; end
            OP_RSB:         begin add_a = op2; add_b = ~rn; add_cin = 1'b1; end
            OP_ADD, OP_CMN: add_cin = 1'b0;
            OP_ADC:         add_cin = nzcv[NZCV_C];
            OP_SBC:         begin add_b = ~op2; add_cin = nzcv[NZCV_C]; end
            OP_RSC:         begin add_a = op2; add_b = ~rn; add_cin = nzcv[NZCV_C]; end
            OP_AND, OP_TST: begin is_arith = 1'b0; logic_res = rn & op2; end
            OP_EOR, OP_TEQ: begin is_arith = 1'b0; logic_res = rn ^ op2; end
            OP_ORR:         begin is_arith = 1'b0; logic_res = rn | op2; end
            OP_MOV:         begin is_arith = 1'b0; logic_res = op2; end
            OP_BIC:         begin is_arith = 1'b0; logic_res = rn & ~op2; end
            OP_MVN:         begin is_arith = 1'b0; logic_res = ~op2; end
        endcase
    end

    assign sum      = {1'b0, add_a} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
    assign alu_res  = is_arith ? sum[DATA_W-1:0] : logic_res;
    assign alu_c    = is_arith ? sum[DATA_W] : shift_c;
    assign alu_v    = is_arith ? ((add_a[DATA_W-1] == add_b[DATA_W-1]) &&
                                  (sum[DATA_W-1] != add_a[DATA_W-1]))
                               : nzcv[NZCV_V];
    assign alu_nzcv = {alu_res[DATA_W-1], alu_res == '0, alu_c, alu_v};

`ifdef ALU_MUL_EN
    logic [DATA_W-1:0] mul_acc, mul_mcand, mul_mplier;
    logic [4:0] mul_cnt;

    assign start_mul  = accept && op_mul && cond_pass;
    assign mul_result = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign mul_done   = (state == ST_MUL) && (mul_cnt == 5'd31);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_cnt    <= '0;
            mul_rd     <= '0;
            mul_s      <= 1'b0;
        end else if (start_mul) begin
            mul_acc    <= '0;
            mul_mcand  <= rn;
            mul_mplier <= op2;
            mul_cnt    <= '0;
            mul_rd     <= rd_tag;
            mul_s      <= s_bit;
        end else if (state == ST_MUL) begin
            mul_acc    <= mul_result;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + 5'd1;
        end
    end
`else
    logic unused_mul;
    assign unused_mul = op_mul;
    assign start_mul  = 1'b0;
    assign mul_done   = 1'b0;
    assign mul_result = '0;
    assign mul_rd     = '0;
    assign mul_s      = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_mul) state_next = ST_MUL;
            ST_MUL:  if (mul_done) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // A failed condition still loads a result slot: zero data, no write, flags kept.
    always_comb begin
        load        = 1'b0;
        load_result = '0;
        load_rd     = rd_tag;
        load_wr     = 1'b0;
        load_nzcv   = nzcv;
        if (mul_done) begin
            load        = 1'b1;
            load_result = mul_result;
            load_rd     = mul_rd;
            load_wr     = 1'b1;
            if (mul_s)
                load_nzcv = {mul_result[DATA_W-1], mul_result == '0,
                             nzcv[NZCV_C], nzcv[NZCV_V]};
        end else if (accept && !start_mul) begin
            load = 1'b1;
            if (cond_pass) begin
                load_result = alu_res;
                load_wr     = !is_compare(opcode);
                if (is_compare(opcode) || s_bit)
                    load_nzcv = alu_nzcv;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            res_valid <= 1'b0;
            result    <= '0;
            rd_out    <= '0;
            wr_en     <= 1'b0;
            nzcv      <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                res_valid <= 1'b1;
                result    <= load_result;
                rd_out    <= load_rd;
                wr_en     <= load_wr;
                nzcv      <= load_nzcv;
            end else if (res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_flags_stage.sv
// Scoreboard bench for alu_flags_stage: directed cases plus randomized ops
// checked against an arithmetic reference model. ALU_MUL_EN adds MUL cases.
module tb_alu_flags_stage;
    import cpu_pkg::*;

`ifdef ALU_MUL_EN
    localparam bit USE_MUL = 1'b1;
`else
    localparam bit USE_MUL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        op_valid, op_ready, s_bit, shift_c, op_mul;
    logic [3:0]  opcode, cond, rd_tag, rd_out, nzcv;
    logic [31:0] rn, op2, result;
    logic        res_valid, res_ready, wr_en;
    alu_state_e  fsm_state;

    always #5 clk = ~clk;

    alu_flags_stage #(.DATA_W(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .opcode    (opcode),
        .s_bit     (s_bit),
        .cond      (cond),
        .rd_tag    (rd_tag),
        .rn        (rn),
        .op2       (op2),
        .shift_c   (shift_c),
        .op_mul    (op_mul),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .rd_out    (rd_out),
        .wr_en     (wr_en),
        .nzcv      (nzcv),
        .fsm_state (fsm_state)
    );

    // Scoreboard entry: {result, rd, wr_en, nzcv}
    logic [40:0] exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [3:0]  m_nzcv;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit model_cond(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic do_add(input logic [31:0] x, input logic [31:0] y, input int cin,
                          output logic [31:0] r, output logic c, output logic v);
        logic [63:0] u;
        longint s;
        u = {32'b0, x} + {32'b0, y} + 64'(cin);
        s = longint'($signed(x)) + longint'($signed(y)) + longint'(cin);
        r = u[31:0];
        c = u[32];
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endtask

    task automatic do_sub(input logic [31:0] x, input logic [31:0] y, input int borrow,
                          output logic [31:0] r, output logic c, output logic v);
        longint s;
        r = x - y - 32'(borrow);
        c = ({32'b0, x} >= ({32'b0, y} + 64'(borrow)));
        s = longint'($signed(x)) - longint'($signed(y)) - longint'(borrow);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endtask

    task automatic model_issue(input logic [3:0] opc, input logic s, input logic [3:0] cnd,
                               input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                               input logic sc, input logic mul);
        logic [31:0] r;
        logic cf, vf;
        bit is_test;
        int cin;
        if (!model_cond(cnd, m_nzcv)) begin
            exp_q.push_back({32'h0, rd, 1'b0, m_nzcv});
            return;
        end
        cin = int'(m_nzcv[1]);
        if (USE_MUL && mul) begin
            r = a * b;
            if (s) m_nzcv = {r[31], r == 32'h0, m_nzcv[1], m_nzcv[0]};
            exp_q.push_back({r, rd, 1'b1, m_nzcv});
            return;
        end
        r = '0; cf = m_nzcv[1]; vf = m_nzcv[0];
        case (opc)
            OP_AND, OP_TST: begin r = a & b; cf = sc; end
            OP_EOR, OP_TEQ: begin r = a ^ b; cf = sc; end
            OP_ORR:         begin r = a | b; cf = sc; end
            OP_MOV:         begin r = b; cf = sc; end
            OP_BIC:         begin r = a & ~b; cf = sc; end
            OP_MVN:         begin r = ~b; cf = sc; end
            OP_ADD, OP_CMN: do_add(a, b, 0, r, cf, vf);
            OP_ADC:         do_add(a, b, cin, r, cf, vf);
            OP_SUB, OP_CMP: do_sub(a, b, 0, r, cf, vf);
            OP_SBC:         do_sub(a, b, 1 - cin, r, cf, vf);
            OP_RSB:         do_sub(b, a, 0, r, cf, vf);
            default:        do_sub(b, a, 1 - cin, r, cf, vf);
        endcase
        is_test = (opc == OP_TST) || (opc == OP_TEQ) || (opc == OP_CMP) || (opc == OP_CMN);
        if (is_test || s) m_nzcv = {r[31], r == 32'h0, cf, vf};
        exp_q.push_back({r, rd, !is_test, m_nzcv});
    endtask

    // Called in the posedge+1 phase; acceptance is decided at the negedge.
    task automatic send(input logic [3:0] opc, input logic s, input logic [3:0] cnd,
                        input logic [3:0] rd, input logic [31:0] a, input logic [31:0] b,
                        input logic sc, input logic mul);
        bit done;
        done = 1'b0;
        opcode = opc; s_bit = s; cond = cnd; rd_tag = rd;
        rn = a; op2 = b; shift_c = sc; op_mul = mul;
        op_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (op_ready) begin
                model_issue(opc, s, cnd, rd, a, b, sc, mul);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        op_valid = 1'b0;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: op_ready stayed 0, required 1");
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({"drain_", name}, 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_word();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    always @(posedge clk) begin
        #1;
        if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops on every result transfer and checks hold during back-pressure.
    logic        prev_stall = 1'b0;
    logic [40:0] prev_out;
    always @(negedge clk) begin
        logic [40:0] act, e;
        act = {result, rd_out, wr_en, nzcv};
        if (reset_n) begin
            if (prev_stall) begin
                checks++;
                if (act !== prev_out) begin
                    errors++;
                    $display("FAIL stall_hold: got %0h expected %0h", act, prev_out);
                end
            end
            if (res_valid && res_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %0h expected none", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        errors++;
                        $display("FAIL result_cmp: got res=%h rd=%h wr=%b nzcv=%b expected res=%h rd=%h wr=%b nzcv=%b",
                                 act[40:9], act[8:5], act[4], act[3:0], e[40:9], e[8:5], e[4], e[3:0]);
                    end
                end
            end
        end
        prev_stall = reset_n && res_valid && !res_ready;
        prev_out   = act;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        op_valid = 1'b1; opcode = OP_ADD; s_bit = 1'b1; cond = COND_AL; rd_tag = 4'hF;
        rn = 32'hFFFF_FFFF; op2 = 32'hFFFF_FFFF; shift_c = 1'b1; op_mul = 1'b1; res_ready = 1'b1;
        m_nzcv = 4'b0000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_result", 64'(result), 64'd0);
        check("rst_rd_out", 64'(rd_out), 64'd0);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_nzcv", 64'(nzcv), 64'd0);
        check("rst_op_ready", 64'(op_ready), 64'd1);
        check("rst_state", 64'(fsm_state), 64'(ST_IDLE));
        op_valid = 1'b0;
        op_mul = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        send(OP_ADD, 1'b1, COND_AL, 4'd1, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        drain("adds");
        check("adds_result", 64'(result), 64'h8000_0000);
        check("adds_nzcv", 64'(nzcv), 64'b1001);

        send(OP_SUB, 1'b1, COND_AL, 4'd2, 32'd5, 32'd5, 1'b0, 1'b0);
        drain("subs");
        check("subs_result", 64'(result), 64'd0);
        check("subs_nzcv", 64'(nzcv), 64'b0110);

        send(OP_MOV, 1'b0, COND_NE, 4'd3, 32'h1234, 32'hAA, 1'b0, 1'b0);
        drain("movne");
        check("movne_wr_en", 64'(wr_en), 64'd0);
        check("movne_result", 64'(result), 64'd0);
        check("movne_nzcv", 64'(nzcv), 64'b0110);

        send(OP_AND, 1'b1, COND_AL, 4'd4, 32'hF0, 32'h0F, 1'b1, 1'b0);
        drain("ands");
        check("ands_result", 64'(result), 64'd0);
        check("ands_nzcv", 64'(nzcv), 64'b0110);

        res_ready = 1'b0;
        send(OP_EOR, 1'b0, COND_AL, 4'd5, 32'h1111_0000, 32'h0000_2222, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_op_ready", 64'(op_ready), 64'd0);
            check("bp_res_valid", 64'(res_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        send(OP_ORR, 1'b0, COND_AL, 4'd6, 32'h0F00, 32'h00F0, 1'b0, 1'b0);
        check("bp_reload_rd", 64'(rd_out), 64'd6);
        check("bp_reload_valid", 64'(res_valid), 64'd1);
        drain("bp");
        check("orr_result", 64'(result), 64'h0FF0);

        send(OP_ADC, 1'b1, COND_AL, 4'd7, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
        drain("adcs");
        check("adcs_result", 64'(result), 64'd0);
        check("adcs_nzcv", 64'(nzcv), 64'b0110);

        send(OP_CMP, 1'b0, COND_AL, 4'd8, 32'd3, 32'd4, 1'b0, 1'b0);
        drain("cmp");
        check("cmp_wr_en", 64'(wr_en), 64'd0);
        check("cmp_nzcv", 64'(nzcv), 64'b1000);

`ifdef ALU_MUL_EN
        send(OP_MOV, 1'b0, COND_AL, 4'd9, 32'd1234, 32'd5678, 1'b0, 1'b1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check("mul_busy", 64'({op_ready, res_valid}), 64'b00);
        end
        @(negedge clk);
        check("mul_done_valid", 64'(res_valid), 64'd1);
        check("mul_result", 64'(result), 64'd7006652);
        @(posedge clk);
        #1;
        drain("mul");

        send(OP_MOV, 1'b0, COND_AL, 4'd10, 32'd1234, 32'd5678, 1'b0, 1'b1);
        repeat (9) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mul_abort_valid", 64'(res_valid), 64'd0);
        check("mul_abort_state", 64'(fsm_state), 64'(ST_IDLE));
        exp_q.delete();
        m_nzcv = 4'b0000;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("mul_abort_no_result", 64'(res_valid), 64'd0);
`endif

        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), rand_word(), rand_word(), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0));
        end
        @(posedge clk);
        #2;
        rand_ready = 1'b0;
        res_ready = 1'b1;
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_flags_stage.md
# alu_flags_stage

Execute stage that sits directly downstream of the barrel shifter: it takes the first operand Rn plus the shifted second operand and shifter carry-out, and performs the ARM data-processing operation. It evaluates the instruction condition against the current NZCV status register, registers the result with a valid/ready handshake, and commits flag updates. Its C flag drives the shifter's carry input (SR29_IN).

## Interface
- DATA_W, 32, operand/result width (only 32 is supported)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op_valid  in  1  upstream presents an operation
- op_ready  out  1  stage accepts; a transfer happens when op_valid && op_ready on a clk edge
- opcode  in  4  ARM data-processing opcode (IR[24:21])
- s_bit  in  1  set-flags bit (IR[20])
- cond  in  4  condition field (IR[31:28])
- rd_tag  in  4  destination register index, passed through
- rn  in  32  first operand
- op2  in  32  shifter output
- shift_c  in  1  shifter carry-out
- op_mul  in  1  multiply request (ignored unless ALU_MUL_EN)
- res_valid  out  1  result register holds an unconsumed result
- res_ready  in  1  downstream consumes; a transfer happens when res_valid && res_ready
- result  out  32  registered result
- rd_out  out  4  registered rd_tag
- wr_en  out  1  write result to rd (registered)
- nzcv  out  4  status register: [3]=N [2]=Z [1]=C [0]=V; nzcv[1] feeds the shifter's SR29_IN

## Operation
- Reset values: res_valid=0, result=0, rd_out=0, wr_en=0, nzcv=0000, FSM=IDLE.
- op_ready = (state==IDLE) && (!res_valid || res_ready).
- On accept, cond is evaluated against the current nzcv (all 16 ARM conditions; 1110 is AL; 1111 is never).
- If cond fails: the result register loads with wr_en=0 and result=0, flags are unchanged, and res_valid=1. Every accepted op produces exactly one result.
- Opcode behaviour:
  - AND/EOR/ORR/BIC/MOV/MVN: logical ops; C=shift_c, V is unchanged.
  - SUB/RSB/CMP/SBC/RSC: C=NOT borrow, V=signed overflow.
  - ADD/ADC/CMN: C=carry-out, V=signed overflow.
  - ADC/SBC/RSC use the current nzcv[1] as carry-in.
- TST/TEQ/CMP/CMN: wr_en=0 and flags always update, regardless of s_bit. All other opcodes: wr_en=1 when cond passes; flags update only if s_bit=1.
- N = result[31]; Z = (result==0), computed on the 32-bit result.
- Flags commit on the same edge that loads the result register, so the next accepted op sees the new flags (no forwarding needed).
- FSM states:
  - IDLE: accepts ops.
  - MUL: multiply in progress (macro only).
  - IDLE→MUL on accept with op_mul=1 and cond pass.
  - MUL→IDLE after 32 iterations; the result loads on that edge.
- Back-pressure: while res_valid && !res_ready, result, rd_out, wr_en and nzcv hold stable.
- Asynchronous reset mid-MUL aborts the operation; no result is produced.

## Timing
- Single-cycle ops: accepted at edge k, so res_valid=1 after edge k. Throughput is 1 op per cycle while res_ready is held high.
- Accept and drain in the same cycle is allowed (the register reloads).
- MUL: accepted at edge k, res_valid=1 after edge k+32, and op_ready=0 throughout.

## Configuration
- ALU_MUL_EN defined: op_mul selects a 32-cycle shift-add multiply.
  - result = low 32 bits of rn*op2.
  - With s_bit=1: N and Z update; C and V are unchanged.
- ALU_MUL_EN undefined: op_mul is ignored, there is no MUL state, and the FSM is always IDLE.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams (OP_AND..OP_MVN)
  - condition localparams (COND_EQ..COND_NV)
  - NZCV bit indices
  - FSM state enum
- Sub-module alu_cond_check: combinational (cond, nzcv) → pass. It is reused by the branch unit.

## Test plan
- Reset with all inputs active → all outputs zero and op_ready=1. Then ADD rn=0x7FFFFFFF, op2=1, s=1 → result=0x80000000, nzcv=1001 one cycle later.
- SUBS rn=5, op2=5 → result=0, nzcv=0110. The next op, MOVNE rn=x, op2=0xAA, cond=0001, is accepted with cond failing → wr_en=0 and nzcv stays 0110.
- ANDS rn=0xF0, op2=0x0F, shift_c=1 → result=0, nzcv=0110 (C comes from the shifter, V is kept).
- Hold res_ready=0 after one op → op_ready=0 and the outputs stay stable for 5 cycles. Then raise res_ready with a new op pending → transfer on the same edge.
- ADCS with C=1: rn=0xFFFFFFFF, op2=0 → result=0, nzcv=0110. CMP rn=3, op2=4 → wr_en=0, nzcv=1000.
- With ALU_MUL_EN: MUL rn=1234, op2=5678 → result=7006652 after 32 cycles, op_ready=0 meanwhile. A second run with reset asserted at cycle 10 → no result and FSM=IDLE.
